// File: rtl/f_axil_slave_chk.sv
// f_axil_slave_chk: passive AXI4-lite property checker bound onto one interface.
// Tracks outstanding AW/W/AR transactions, stall and response-age timers and
// AW/W skew, and latches any violation into the sticky f_err vector.
// F_DUT_IS_MASTER selects which f_err groups are asserted and which are assumed
// under FORMAL.
// Optional build macro F_AXIL_CHK_COVER_EN adds handshake/corner cover properties.
// The FORMAL macro compiles the assert/assume set.
// f_err: [0] B w/o outstanding, [1] R w/o outstanding, [2] request stability,
//        [3] response stability, [4] request stall, [5] response stall,
//        [6] age/delay, [7] overflow or skew.
module f_axil_slave_chk #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned F_DUT_IS_MASTER = 0,
    parameter int unsigned F_OSTD_MAX      = 16,
    parameter int unsigned F_SKEW_MAX      = 4,
    parameter int unsigned F_REQ_STALL_MAX = 16,
    parameter int unsigned F_RSP_STALL_MAX = 16,
    parameter int unsigned F_DELAY_MAX     = 64,
    localparam int unsigned CW             = $clog2(F_OSTD_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    input  logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    input  logic                  s_axil_wready,
    input  logic [1:0]            s_axil_bresp,
    input  logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    input  logic                  s_axil_arready,
    input  logic [DATA_WIDTH-1:0] s_axil_rdata,
    input  logic [1:0]            s_axil_rresp,
    input  logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [CW-1:0]         f_aw_outstanding,
    output logic [CW-1:0]         f_w_outstanding,
    output logic [CW-1:0]         f_ar_outstanding,
    output logic [7:0]            f_err
);

    localparam int unsigned QW  = $clog2(F_REQ_STALL_MAX + 1);
    localparam int unsigned PW  = $clog2(F_RSP_STALL_MAX + 1);
    localparam int unsigned AGW = $clog2(F_DELAY_MAX + 1);

    // Saturating outstanding counter; simultaneous request+response holds.
    function automatic logic [CW-1:0] cnt_nxt(input logic [CW-1:0] c, input logic req, input logic rsp);
        if (req && !rsp && c != CW'(F_OSTD_MAX)) cnt_nxt = c + CW'(1);
        else if (rsp && !req && c != '0)          cnt_nxt = c - CW'(1);
        else                                      cnt_nxt = c;
    endfunction

    // Request-channel stall timer: counts valid&&!ready cycles, saturating.
    function automatic logic [QW-1:0] qst_nxt(input logic stall, input logic [QW-1:0] t);
        if (!stall)                             qst_nxt = '0;
        else if (t == QW'(F_REQ_STALL_MAX))     qst_nxt = t;
        else                                    qst_nxt = t + QW'(1);
    endfunction

    // Response-channel stall timer.
    function automatic logic [PW-1:0] pst_nxt(input logic stall, input logic [PW-1:0] t);
        if (!stall)                             pst_nxt = '0;
        else if (t == PW'(F_RSP_STALL_MAX))     pst_nxt = t;
        else                                    pst_nxt = t + PW'(1);
    endfunction

    // Response age: runs while work is outstanding, restarts on each response.
    function automatic logic [AGW-1:0] age_nxt(input logic [CW-1:0] c, input logic rsp, input logic [AGW-1:0] a);
        if (c == '0 || rsp)                     age_nxt = '0;
        else if (a == AGW'(F_DELAY_MAX))        age_nxt = a;
        else                                    age_nxt = a + AGW'(1);
    endfunction

    logic [CW-1:0]         r_aw_cnt, r_w_cnt, r_ar_cnt;
    logic [QW-1:0]         r_aw_stall, r_w_stall, r_ar_stall;
    logic [PW-1:0]         r_b_stall, r_r_stall;
    logic [AGW-1:0]        r_aw_age, r_w_age, r_ar_age;
    logic                  r_aw_hold, r_w_hold, r_ar_hold, r_b_hold, r_r_hold;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [2:0]            r_awprot, r_arprot;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [1:0]            r_bresp, r_rresp;
    logic [7:0]            r_err;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic [CW-1:0]         w_aw_cnt_nxt, w_w_cnt_nxt, w_ar_cnt_nxt, w_skew;
    logic [QW-1:0]         w_aw_stall_nxt, w_w_stall_nxt, w_ar_stall_nxt;
    logic [PW-1:0]         w_b_stall_nxt, w_r_stall_nxt;
    logic [AGW-1:0]        w_aw_age_nxt, w_w_age_nxt, w_ar_age_nxt;
    logic [7:0]            w_viol;

    assign w_aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_w_hs  = s_axil_wvalid  && s_axil_wready;
    assign w_ar_hs = s_axil_arvalid && s_axil_arready;
    assign w_b_hs  = s_axil_bvalid  && s_axil_bready;
    assign w_r_hs  = s_axil_rvalid  && s_axil_rready;

    assign w_aw_cnt_nxt   = cnt_nxt(r_aw_cnt, w_aw_hs, w_b_hs);
    assign w_w_cnt_nxt    = cnt_nxt(r_w_cnt,  w_w_hs,  w_b_hs);
    assign w_ar_cnt_nxt   = cnt_nxt(r_ar_cnt, w_ar_hs, w_r_hs);
    assign w_aw_stall_nxt = qst_nxt(s_axil_awvalid && !s_axil_awready, r_aw_stall);
    assign w_w_stall_nxt  = qst_nxt(s_axil_wvalid  && !s_axil_wready,  r_w_stall);
    assign w_ar_stall_nxt = qst_nxt(s_axil_arvalid && !s_axil_arready, r_ar_stall);
    assign w_b_stall_nxt  = pst_nxt(s_axil_bvalid  && !s_axil_bready,  r_b_stall);
    assign w_r_stall_nxt  = pst_nxt(s_axil_rvalid  && !s_axil_rready,  r_r_stall);
    assign w_aw_age_nxt   = age_nxt(r_aw_cnt, w_b_hs, r_aw_age);
    assign w_w_age_nxt    = age_nxt(r_w_cnt,  w_b_hs, r_w_age);
    assign w_ar_age_nxt   = age_nxt(r_ar_cnt, w_r_hs, r_ar_age);
    // Skew and timer limits are judged on the values the next edge will hold.
    assign w_skew = (w_aw_cnt_nxt >= w_w_cnt_nxt) ? (w_aw_cnt_nxt - w_w_cnt_nxt)
                                                  : (w_w_cnt_nxt - w_aw_cnt_nxt);

    // Violation detectors evaluated against the current cycle's inputs.
    always_comb begin
        w_viol    = '0;
        w_viol[0] = s_axil_bvalid && (r_aw_cnt == '0 || r_w_cnt == '0);
        w_viol[1] = s_axil_rvalid && (r_ar_cnt == '0);
        w_viol[2] = (r_aw_hold && (!s_axil_awvalid || s_axil_awaddr != r_awaddr || s_axil_awprot != r_awprot))
                 || (r_w_hold  && (!s_axil_wvalid  || s_axil_wdata  != r_wdata  || s_axil_wstrb  != r_wstrb))
                 || (r_ar_hold && (!s_axil_arvalid || s_axil_araddr != r_araddr || s_axil_arprot != r_arprot));
        w_viol[3] = (r_b_hold && (!s_axil_bvalid || s_axil_bresp != r_bresp))
                 || (r_r_hold && (!s_axil_rvalid || s_axil_rdata != r_rdata || s_axil_rresp != r_rresp));
        w_viol[4] = (w_aw_stall_nxt == QW'(F_REQ_STALL_MAX)) || (w_w_stall_nxt == QW'(F_REQ_STALL_MAX))
                 || (w_ar_stall_nxt == QW'(F_REQ_STALL_MAX));
        w_viol[5] = (w_b_stall_nxt == PW'(F_RSP_STALL_MAX)) || (w_r_stall_nxt == PW'(F_RSP_STALL_MAX));
        w_viol[6] = (w_aw_age_nxt == AGW'(F_DELAY_MAX)) || (w_w_age_nxt == AGW'(F_DELAY_MAX))
                 || (w_ar_age_nxt == AGW'(F_DELAY_MAX));
        w_viol[7] = (w_aw_hs && r_aw_cnt == CW'(F_OSTD_MAX)) || (w_w_hs && r_w_cnt == CW'(F_OSTD_MAX))
                 || (w_ar_hs && r_ar_cnt == CW'(F_OSTD_MAX)) || (32'(w_skew) > F_SKEW_MAX);
    end

    // Tracking state, previous-cycle payload snapshot and sticky error vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_cnt   <= '0;  r_w_cnt   <= '0;  r_ar_cnt   <= '0;
            r_aw_stall <= '0;  r_w_stall <= '0;  r_ar_stall <= '0;
            r_b_stall  <= '0;  r_r_stall <= '0;
            r_aw_age   <= '0;  r_w_age   <= '0;  r_ar_age   <= '0;
            r_aw_hold  <= 1'b0; r_w_hold <= 1'b0; r_ar_hold <= 1'b0;
            r_b_hold   <= 1'b0; r_r_hold <= 1'b0;
            r_awaddr   <= '0;  r_awprot  <= '0;  r_araddr   <= '0;  r_arprot <= '0;
            r_wdata    <= '0;  r_wstrb   <= '0;  r_rdata    <= '0;  r_rresp  <= '0;
            r_bresp    <= '0;
            r_err      <= '0;
        end else begin
            r_aw_cnt   <= w_aw_cnt_nxt;   r_w_cnt   <= w_w_cnt_nxt;   r_ar_cnt   <= w_ar_cnt_nxt;
            r_aw_stall <= w_aw_stall_nxt; r_w_stall <= w_w_stall_nxt; r_ar_stall <= w_ar_stall_nxt;
            r_b_stall  <= w_b_stall_nxt;  r_r_stall <= w_r_stall_nxt;
            r_aw_age   <= w_aw_age_nxt;   r_w_age   <= w_w_age_nxt;   r_ar_age   <= w_ar_age_nxt;
            r_aw_hold  <= s_axil_awvalid && !s_axil_awready;
            r_w_hold   <= s_axil_wvalid  && !s_axil_wready;
            r_ar_hold  <= s_axil_arvalid && !s_axil_arready;
            r_b_hold   <= s_axil_bvalid  && !s_axil_bready;
            r_r_hold   <= s_axil_rvalid  && !s_axil_rready;
            r_awaddr   <= s_axil_awaddr;  r_awprot  <= s_axil_awprot;
            r_araddr   <= s_axil_araddr;  r_arprot  <= s_axil_arprot;
            r_wdata    <= s_axil_wdata;   r_wstrb   <= s_axil_wstrb;
            r_rdata    <= s_axil_rdata;   r_rresp   <= s_axil_rresp;
            r_bresp    <= s_axil_bresp;
            r_err      <= r_err | w_viol;
        end
    end

    assign f_aw_outstanding = r_aw_cnt;
    assign f_w_outstanding  = r_w_cnt;
    assign f_ar_outstanding = r_ar_cnt;
    assign f_err            = r_err;

`ifdef FORMAL
    // Groups checked on the B/R side; the remaining groups belong to the request side.
    localparam logic [7:0] RSP_SIDE    = 8'b0110_1011;
    localparam logic [7:0] ASSERT_MASK = (F_DUT_IS_MASTER == 0) ? RSP_SIDE : ~RSP_SIDE;

    logic r_f_past_valid = 1'b0;
    logic r_f_rst_exit;

    // Marks the first solver step and the first cycle after reset release.
    always_ff @(posedge clk) r_f_past_valid <= 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_f_rst_exit <= 1'b1;
        else        r_f_rst_exit <= 1'b0;
    end

    // Start every trace in reset.
    always_comb if (!r_f_past_valid) assume (!rst_n);

    for (genvar k = 0; k < 8; k++) begin : g_prop
        if (ASSERT_MASK[k]) begin : g_asrt
            a_viol: assert property (@(posedge clk) disable iff (!rst_n) !w_viol[k]);
        end else begin : g_asum
            m_viol: assume property (@(posedge clk) disable iff (!rst_n) !w_viol[k]);
        end
    end

    if (F_DUT_IS_MASTER == 0) begin : g_rx_asum
        m_rst_exit: assume property (@(posedge clk) disable iff (!rst_n) r_f_rst_exit |->
            !(s_axil_awvalid || s_axil_wvalid || s_axil_arvalid || s_axil_bvalid || s_axil_rvalid));
    end else begin : g_rx_asrt
        a_rst_exit: assert property (@(posedge clk) disable iff (!rst_n) r_f_rst_exit |->
            !(s_axil_awvalid || s_axil_wvalid || s_axil_arvalid || s_axil_bvalid || s_axil_rvalid));
    end
`endif

`ifdef F_AXIL_CHK_COVER_EN
    // Reachability of handshakes, full read queue, skew limit and back-to-back B.
    c_aw_hs:   cover property (@(posedge clk) disable iff (!rst_n) w_aw_hs);
    c_w_hs:    cover property (@(posedge clk) disable iff (!rst_n) w_w_hs);
    c_ar_hs:   cover property (@(posedge clk) disable iff (!rst_n) w_ar_hs);
    c_b_hs:    cover property (@(posedge clk) disable iff (!rst_n) w_b_hs);
    c_r_hs:    cover property (@(posedge clk) disable iff (!rst_n) w_r_hs);
    c_ar_full: cover property (@(posedge clk) disable iff (!rst_n) r_ar_cnt == CW'(F_OSTD_MAX));
    c_skew:    cover property (@(posedge clk) disable iff (!rst_n)
                   32'((r_aw_cnt >= r_w_cnt) ? (r_aw_cnt - r_w_cnt) : (r_w_cnt - r_aw_cnt)) == F_SKEW_MAX);
    c_b_b2b:   cover property (@(posedge clk) disable iff (!rst_n) w_b_hs ##1 w_b_hs);
`endif

endmodule

// File: tb/tb_f_axil_slave_chk.sv
// Bench for f_axil_slave_chk: directed scenarios with literal expectations plus a
// timestamp-based reference model compared against the DUT on every falling edge.
module tb_f_axil_slave_chk;

    localparam int OSTD = 4;
    localparam int SKEW = 2;
    localparam int REQ  = 4;
    localparam int RSP  = 6;
    localparam int DLY  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
    logic [2:0]  s_axil_awprot, s_axil_arprot;
    logic [3:0]  s_axil_wstrb;
    logic [1:0]  s_axil_bresp, s_axil_rresp;
    logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic        s_axil_rvalid, s_axil_rready;
    logic [2:0]  f_aw_outstanding, f_w_outstanding, f_ar_outstanding;
    logic [7:0]  f_err;

    int n_vec = 0;
    int n_bad = 0;

    f_axil_slave_chk #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .F_DUT_IS_MASTER(0), .F_OSTD_MAX(OSTD),
        .F_SKEW_MAX(SKEW), .F_REQ_STALL_MAX(REQ), .F_RSP_STALL_MAX(RSP), .F_DELAY_MAX(DLY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .f_aw_outstanding(f_aw_outstanding), .f_w_outstanding(f_w_outstanding),
        .f_ar_outstanding(f_ar_outstanding), .f_err(f_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int aw, input int w, input int ar, input int err);
        chk({tag, "_aw"},  int'(f_aw_outstanding), aw);
        chk({tag, "_w"},   int'(f_w_outstanding),  w);
        chk({tag, "_ar"},  int'(f_ar_outstanding), ar);
        chk({tag, "_err"}, int'(f_err),            err);
    endtask

    // Reference model: channels 0 AW, 1 W, 2 AR, 3 B, 4 R.
    // Timers are kept as start timestamps instead of running counters.
    int          cyc = 0;
    int          m_cnt [3];
    int          pc [3];
    int          sst [5];
    int          aorg [3];
    logic [7:0]  m_err = '0;
    logic [4:0]  mv, mr, mhs, phold;
    logic [2:0]  mrsp;
    logic [63:0] mpay [5];
    logic [63:0] ppay [5];
    int          lim, d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_err = '0;
            phold = '0;
            for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; aorg[k] = 0; end
            for (int k = 0; k < 5; k++) sst[k] = -1;
        end else begin
            cyc++;
            mv  = {s_axil_rvalid, s_axil_bvalid, s_axil_arvalid, s_axil_wvalid, s_axil_awvalid};
            mr  = {s_axil_rready, s_axil_bready, s_axil_arready, s_axil_wready, s_axil_awready};
            mhs = mv & mr;
            mrsp = {mhs[4], mhs[3], mhs[3]};
            mpay[0] = 64'({s_axil_awprot, s_axil_awaddr});
            mpay[1] = 64'({s_axil_wstrb, s_axil_wdata});
            mpay[2] = 64'({s_axil_arprot, s_axil_araddr});
            mpay[3] = 64'(s_axil_bresp);
            mpay[4] = 64'({s_axil_rresp, s_axil_rdata});
            for (int k = 0; k < 3; k++) pc[k] = m_cnt[k];
            if (mv[3] && (pc[0] == 0 || pc[1] == 0)) m_err[0] = 1'b1;
            if (mv[4] && pc[2] == 0) m_err[1] = 1'b1;
            for (int ch = 0; ch < 5; ch++) begin
                if (phold[ch] && (!mv[ch] || mpay[ch] != ppay[ch])) m_err[(ch < 3) ? 2 : 3] = 1'b1;
                lim = (ch < 3) ? REQ : RSP;
                if (mv[ch] && !mr[ch]) begin
                    if (sst[ch] < 0) sst[ch] = cyc;
                    if (cyc - sst[ch] + 1 >= lim) m_err[(ch < 3) ? 4 : 5] = 1'b1;
                end else begin
                    sst[ch] = -1;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (mhs[k] && pc[k] == OSTD) m_err[7] = 1'b1;
                if (pc[k] == 0 || mrsp[k]) aorg[k] = cyc;
                else if (cyc - aorg[k] >= DLY) m_err[6] = 1'b1;
                if (mhs[k] && !mrsp[k])      m_cnt[k] = (pc[k] < OSTD) ? pc[k] + 1 : OSTD;
                else if (mrsp[k] && !mhs[k]) m_cnt[k] = (pc[k] > 0) ? pc[k] - 1 : 0;
            end
            d = m_cnt[0] - m_cnt[1];
            if (d < 0) d = -d;
            if (d > SKEW) m_err[7] = 1'b1;
            phold = mv & ~mr;
            for (int ch = 0; ch < 5; ch++) ppay[ch] = mpay[ch];
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("mdl_aw",  int'(f_aw_outstanding), m_cnt[0]);
        chk("mdl_w",   int'(f_w_outstanding),  m_cnt[1]);
        chk("mdl_ar",  int'(f_ar_outstanding), m_cnt[2]);
        chk("mdl_err", int'(f_err),            int'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 0; s_axil_awready = 0;
        s_axil_wdata  = '0; s_axil_wstrb  = '0; s_axil_wvalid  = 0; s_axil_wready  = 0;
        s_axil_bresp  = '0; s_axil_bvalid = 0;  s_axil_bready  = 0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 0; s_axil_arready = 0;
        s_axil_rdata  = '0; s_axil_rresp  = '0; s_axil_rvalid  = 0; s_axil_rready  = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        idle();
        step();
        step();
        chk_all("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        step();

        // Write flow: AW, W, B one cycle apart.
        s_axil_awvalid = 1; s_axil_awready = 1; s_axil_awaddr = 32'h100; step(); idle();
        chk_all("wr1", 1, 0, 0, 0);
        s_axil_wvalid = 1; s_axil_wready = 1; s_axil_wdata = 32'hDEADBEEF; s_axil_wstrb = 4'hF; step(); idle();
        chk_all("wr2", 1, 1, 0, 0);
        s_axil_bvalid = 1; s_axil_bready = 1; step(); idle();
        chk_all("wr3", 0, 0, 0, 0);

        // Read flow.
        s_axil_arvalid = 1; s_axil_arready = 1; s_axil_araddr = 32'h200; step(); idle();
        chk_all("rd1", 0, 0, 1, 0);
        s_axil_rvalid = 1; s_axil_rready = 1; s_axil_rdata = 32'h1234; step(); idle();
        chk_all("rd2", 0, 0, 0, 0);

        // Early B: one AW accepted, no W yet.
        do_reset();
        s_axil_awvalid = 1; s_axil_awready = 1; step(); idle();
        chk_all("eb1", 1, 0, 0, 0);
        s_axil_bvalid = 1; step();
        chk_all("eb2", 1, 0, 0, 8'h01);
        s_axil_bready = 1; step(); idle();
        step();
        chk_all("eb3", 0, 0, 0, 8'h01);

        // R payload changes while stalled.
        do_reset();
        s_axil_arvalid = 1; s_axil_arready = 1; step(); idle();
        s_axil_rvalid = 1; s_axil_rdata = 32'hA5; step();
        chk_all("rp1", 0, 0, 1, 0);
        s_axil_rdata = 32'h5A; step();
        chk_all("rp2", 0, 0, 1, 8'h08);
        s_axil_rready = 1; step(); idle();
        chk_all("rp3", 0, 0, 0, 8'h08);

        // AR request stall reaching the limit on the 4th edge.
        do_reset();
        s_axil_arvalid = 1; s_axil_araddr = 32'h20;
        repeat (3) step();
        chk_all("rs3", 0, 0, 0, 0);
        step();
        chk_all("rs4", 0, 0, 0, 8'h10);
        s_axil_arready = 1; step(); idle();
        chk_all("rs5", 0, 0, 1, 8'h10);

        // Response age limit.
        do_reset();
        s_axil_arvalid = 1; s_axil_arready = 1; step(); idle();
        repeat (7) step();
        chk_all("ag7", 0, 0, 1, 0);
        step();
        chk_all("ag8", 0, 0, 1, 8'h40);

        // B response stall limit.
        do_reset();
        s_axil_awvalid = 1; s_axil_awready = 1; s_axil_wvalid = 1; s_axil_wready = 1; step(); idle();
        s_axil_bvalid = 1;
        repeat (5) step();
        chk_all("bs5", 1, 1, 0, 0);
        step();
        chk_all("bs6", 1, 1, 0, 8'h20);
        s_axil_bready = 1; step(); idle();
        chk_all("bs7", 0, 0, 0, 8'h20);

        // Overflow: fifth paired request with both counters full, then drain.
        do_reset();
        s_axil_awvalid = 1; s_axil_awready = 1; s_axil_wvalid = 1; s_axil_wready = 1;
        repeat (4) step();
        chk_all("ov4", 4, 4, 0, 0);
        step(); idle();
        chk_all("ov5", 4, 4, 0, 8'h80);
        s_axil_bvalid = 1; s_axil_bready = 1;
        repeat (4) step();
        idle();
        chk_all("ov9", 0, 0, 0, 8'h80);

        // R without outstanding AR.
        do_reset();
        s_axil_rvalid = 1; s_axil_rready = 1; step(); idle();
        chk_all("rn", 0, 0, 0, 8'h02);

        // AW address changes while stalled.
        do_reset();
        s_axil_awvalid = 1; s_axil_awaddr = 32'h10; step();
        s_axil_awaddr = 32'h14; step();
        chk_all("as2", 0, 0, 0, 8'h04);
        s_axil_awready = 1; step(); idle();
        chk_all("as3", 1, 0, 0, 8'h04);

        // Skew on the third unmatched AW, then async reset before the next edge.
        do_reset();
        s_axil_awvalid = 1; s_axil_awready = 1;
        repeat (2) step();
        chk_all("sk2", 2, 0, 0, 0);
        step(); idle();
        chk_all("sk3", 3, 0, 0, 8'h80);
        rst_n = 1'b0;
        #1;
        chk_all("arst", 0, 0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/f_axil_slave_chk.md
Name: f_axil_slave_chk

Overview:
- Next-generation AXI4-lite property checker: a passive module bound onto one AXI4-lite interface.
- Generalises the existing single-purpose slave checker:
  - selectable side (DUT as slave or as master), which swaps assume/assert direction;
  - parametrised counter widths;
  - per-channel response age tracking and AW/W skew limit;
  - a sticky error vector, so the same block serves both formal runs and simulation benches.

Parameters:
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, wstrb width
- F_DUT_IS_MASTER, 0, 0: DUT drives the slave side (request channels assumed, response channels asserted); 1: reverse
- F_OSTD_MAX, 16, maximum outstanding transactions per channel
- F_SKEW_MAX, 4, maximum allowed |AW accepted − W accepted| difference
- F_REQ_STALL_MAX, 16, maximum cycles AW/W/AR valid may wait for ready
- F_RSP_STALL_MAX, 16, maximum cycles B/R valid may wait for ready
- F_DELAY_MAX, 64, maximum cycles from oldest outstanding request to its response
- CW, $clog2(F_OSTD_MAX+1), outstanding counter width (derived, not overridable)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_axil_awaddr/awprot/awvalid/awready  input  ADDR_WIDTH/3/1/1  AW channel
- s_axil_wdata/wstrb/wvalid/wready  input  DATA_WIDTH/STRB_WIDTH/1/1  W channel
- s_axil_bresp/bvalid/bready  input  2/1/1  B channel
- s_axil_araddr/arprot/arvalid/arready  input  ADDR_WIDTH/3/1/1  AR channel
- s_axil_rdata/rresp/rvalid/rready  input  DATA_WIDTH/2/1/1  R channel
- f_aw_outstanding  output  CW  accepted AW not yet answered by B
- f_w_outstanding  output  CW  accepted W not yet answered by B
- f_ar_outstanding  output  CW  accepted AR not yet answered by R
- f_err  output  8  sticky violation flags, bit map below

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, all counters, age/stall timers and f_err clear to 0 immediately.
- Handshake definitions: handshake = valid&&ready sampled at posedge with rst_n=1.
- Outstanding counters:
  - +1 on request handshake without response handshake; −1 on response handshake without request handshake; hold otherwise.
  - The W counter uses the B handshake as its response.
  - Counters saturate at F_OSTD_MAX and never go below 0.
- Response legality: bvalid requires registered f_aw_outstanding>0 AND f_w_outstanding>0. rvalid requires f_ar_outstanding>0. A same-cycle request+response on an empty counter is a violation.
- Stability: after valid&&!ready, the next cycle must keep valid=1 and payload stable (addr/prot, data/strb, resp/data).
- Reset exit: first cycle after reset deassertion, all valids =0.
- Stall timers: one per channel; increment while valid&&!ready, clear otherwise; saturate. Violation when timer reaches the channel's *_STALL_MAX.
- Age timers:
  - aw_age/w_age/ar_age increment every cycle while the matching counter is >0.
  - They clear on the response handshake and whenever the counter is 0.
  - Violation when age reaches F_DELAY_MAX.
- Skew: violation when |f_aw_outstanding − f_w_outstanding| > F_SKEW_MAX.
- Overflow: violation when a request handshake occurs with its counter == F_OSTD_MAX.
- f_err bits (set on violation, held until reset):
  - [0] B without outstanding
  - [1] R without outstanding
  - [2] request stability
  - [3] response stability
  - [4] request stall
  - [5] response stall
  - [6] age/delay
  - [7] overflow or skew
- Formal direction:
  - Properties on DUT outputs are asserted; properties on environment-driven signals are assumed.
  - F_DUT_IS_MASTER=0: assert 1,3,5,6,0 (B/R side); assume 2,4,7 plus the reset-exit rule.
  - F_DUT_IS_MASTER=1: assignment swaps.
  - Initial cycle assumes rst_n=0.

Optional Feature:
- F_AXIL_CHK_COVER_EN defined:
  - adds cover properties for each channel handshake;
  - adds covers for f_ar_outstanding==F_OSTD_MAX and aw/w skew==F_SKEW_MAX;
  - adds covers for back-to-back B handshakes.
- Undefined: no cover statements are compiled.
- Assertions, assumptions and f_err are identical in both builds.

Test Plan:
- Reset: rst_n low mid-transaction with f_aw_outstanding=3 -> all outputs 0 in the same cycle, before the next clk edge.
- Write flow: AW hs then W hs then B hs, one cycle apart -> counters 1,1 then 0,0; f_err=0.
- Early B: bvalid=1 with f_aw_outstanding=1, f_w_outstanding=0 -> f_err[0]=1 next cycle and stays 1.
- Payload change: rvalid held with rready=0, rdata changes 0xA5 -> 0x5A -> f_err[3]=1.
- Stall: F_REQ_STALL_MAX=4, arvalid=1 arready=0 for 4 cycles -> f_err[4]=1 after the 4th edge.
- Skew: F_SKEW_MAX=2, three AW handshakes with no W -> f_err[7]=1 on the third.
